// File: rtl/bcd_to_binary_pkg.sv
// Shared constants and state encoding for the reverse double-dabble BCD-to-binary converter.
package bcd_to_binary_pkg;

  typedef enum logic [2:0] {
    IDLE              = 3'b000,
    SHIFT             = 3'b001,
    CHECK_SHIFT_INDEX = 3'b010,
    SUB               = 3'b011,
    CHECK_DIGIT_INDEX = 3'b100,
    DONE              = 3'b101
  } state_t;

  localparam int         DIGIT_W          = 4;
  localparam logic [3:0] CORR_THRESHOLD   = 4'd8;
  localparam logic [3:0] CORR_OFFSET      = 4'd3;
  localparam logic [3:0] MAX_VALID_DIGIT  = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit correction for reverse double-dabble: a digit of 8 or more loses 3 after a right shift.
module bcd_digit_adjust
  import bcd_to_binary_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  // Correct a digit that received a carried half-ten from the digit above
  always_comb begin
    adjusted = digit;
    if (digit >= CORR_THRESHOLD) begin
      adjusted = digit - CORR_OFFSET;
    end else begin
      adjusted = digit;
    end
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter: one shift per iteration, then one digit corrected per state visit.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DECIMAL_DIGITS = 3,
  parameter int OUTPUT_WIDTH   = 10
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
  input  logic                          i_Start,
  output logic [OUTPUT_WIDTH-1:0]       o_Binary,
  output logic                          o_DV,
  output logic                          o_Busy,
  output logic                          o_Error,
  output logic                          o_Overflow
);

  localparam int BCD_W = DECIMAL_DIGITS * DIGIT_W;
  localparam int TOT_W = BCD_W + OUTPUT_WIDTH;
  localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;

  state_t               r_State;
  logic [BCD_W-1:0]     r_BCD;
  logic [OUTPUT_WIDTH-1:0] r_Bin;
  logic [7:0]           r_Loop_Count;
  logic [IDX_W-1:0]     r_Digit_Index;
  logic                 r_Err;

  logic [TOT_W-1:0]     cat_s;
  logic [TOT_W-1:0]     shifted_s;
  logic [DIGIT_W-1:0]   digit_sel_s;
  logic [DIGIT_W-1:0]   digit_adj_s;
  logic                 invalid_s;

  assign cat_s       = {r_BCD, r_Bin};
  assign shifted_s   = cat_s >> 1;
  assign digit_sel_s = r_BCD[r_Digit_Index*DIGIT_W +: DIGIT_W];

  bcd_digit_adjust u_adjust (
    .digit    (digit_sel_s),
    .adjusted (digit_adj_s)
  );

  // Flag any incoming digit outside 0..9
  always_comb begin
    invalid_s = 1'b0;
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      invalid_s = invalid_s | (i_BCD[i*DIGIT_W +: DIGIT_W] > MAX_VALID_DIGIT);
    end
  end

  // Conversion FSM with registered outputs
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State       <= IDLE;
      r_BCD         <= '0;
      r_Bin         <= '0;
      r_Loop_Count  <= 8'd0;
      r_Digit_Index <= '0;
      r_Err         <= 1'b0;
      o_Binary      <= '0;
      o_DV          <= 1'b0;
      o_Busy        <= 1'b0;
      o_Error       <= 1'b0;
      o_Overflow    <= 1'b0;
    end else begin
      o_DV <= 1'b0;
      case (r_State)
        IDLE: begin
          if (i_Start) begin
            r_BCD         <= i_BCD;
            r_Bin         <= '0;
            r_Err         <= invalid_s;
            r_Loop_Count  <= 8'd0;
            r_Digit_Index <= '0;
            o_Busy        <= 1'b1;
            r_State       <= SHIFT;
          end else begin
            o_Busy        <= 1'b0;
          end
        end
        SHIFT: begin
          r_BCD   <= shifted_s[TOT_W-1:OUTPUT_WIDTH];
          r_Bin   <= shifted_s[OUTPUT_WIDTH-1:0];
          r_State <= CHECK_SHIFT_INDEX;
        end
        // The final shift skips correction, so remaining BCD bits mean overflow
        CHECK_SHIFT_INDEX: begin
          if (r_Loop_Count == 8'(OUTPUT_WIDTH-1)) begin
            r_Loop_Count <= 8'd0;
            r_State      <= DONE;
          end else begin
            r_Loop_Count <= r_Loop_Count + 8'd1;
            r_State      <= SUB;
          end
        end
        SUB: begin
          r_BCD[r_Digit_Index*DIGIT_W +: DIGIT_W] <= digit_adj_s;
          r_State <= CHECK_DIGIT_INDEX;
        end
        CHECK_DIGIT_INDEX: begin
          if (r_Digit_Index == IDX_W'(DECIMAL_DIGITS-1)) begin
            r_Digit_Index <= '0;
            r_State       <= SHIFT;
          end else begin
            r_Digit_Index <= r_Digit_Index + 1'b1;
            r_State       <= SUB;
          end
        end
        DONE: begin
          o_DV       <= 1'b1;
          o_Error    <= r_Err;
          o_Overflow <= (r_BCD != '0) & ~r_Err;
          o_Binary   <= r_Err ? '0 : r_Bin;
          o_Busy     <= 1'b0;
          r_State    <= IDLE;
        end
        default: begin
          o_Busy  <= 1'b0;
          r_State <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: a decimal-arithmetic model predicts every DV cycle and result.
module tb_bcd_to_binary;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b0;
  logic [11:0] bcd_a   = 12'h000;
  logic        start_a = 1'b0;
  logic [9:0]  bin_a;
  logic        dv_a, busy_a, err_a, ovf_a;
  logic [7:0]  bcd_b   = 8'h00;
  logic        start_b = 1'b0;
  logic [3:0]  bin_b;
  logic        dv_b, busy_b, err_b, ovf_b;

  always #5 i_Clock = ~i_Clock;

  bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(10)) dut_a (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_BCD(bcd_a), .i_Start(start_a),
    .o_Binary(bin_a), .o_DV(dv_a), .o_Busy(busy_a), .o_Error(err_a), .o_Overflow(ovf_a));

  bcd_to_binary #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(4)) dut_b (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_BCD(bcd_b), .i_Start(start_b),
    .o_Binary(bin_b), .o_DV(dv_b), .o_Busy(busy_b), .o_Error(err_b), .o_Overflow(ovf_b));

  typedef struct {
    int st;
    int due;
    int bin;
    bit err;
    bit ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   last_due_a = 0;
  int   last_due_b = 0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  localparam int LAT_A = 9 * 8 + 3;
  localparam int LAT_B = 3 * 6 + 3;

  always @(posedge i_Clock) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Decimal value of the digits, then reduced to the output width
  function automatic void model(input int bcd, input int nd, input int w,
                                output int bin, output bit err, output bit ovf);
    int v;
    v   = 0;
    err = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      int d;
      d = (bcd >> (4 * i)) & 15;
      if (d > 9) err = 1'b1;
      v = v * 10 + d;
    end
    bin = err ? 0 : (v % (1 << w));
    ovf = !err && (v >= (1 << w));
  endfunction

  always @(negedge i_Clock) begin
    bit m_dv;
    m_dv = (q_a.size() > 0) && (q_a[0].due == cyc);
    check("dv_a", dv_a, m_dv);
    check("busy_a", busy_a, (q_a.size() > 0) && (cyc >= q_a[0].st) && (cyc < q_a[0].due));
    if (m_dv) begin
      check("bin_a", bin_a, q_a[0].bin);
      check("err_a", err_a, q_a[0].err);
      check("ovf_a", ovf_a, q_a[0].ovf);
      void'(q_a.pop_front());
    end
  end

  always @(negedge i_Clock) begin
    bit m_dv;
    m_dv = (q_b.size() > 0) && (q_b[0].due == cyc);
    check("dv_b", dv_b, m_dv);
    check("busy_b", busy_b, (q_b.size() > 0) && (cyc >= q_b[0].st) && (cyc < q_b[0].due));
    if (m_dv) begin
      check("bin_b", bin_b, q_b[0].bin);
      check("err_b", err_b, q_b[0].err);
      check("ovf_b", ovf_b, q_b[0].ovf);
      void'(q_b.pop_front());
    end
  end

  // Called at a negedge; the start is sampled at the next rising edge
  task automatic go_a(input logic [11:0] v);
    exp_t e;
    if (cyc >= last_due_a) begin
      model(int'(v), 3, 10, e.bin, e.err, e.ovf);
      e.st = cyc + 1;
      e.due = cyc + 1 + LAT_A;
      last_due_a = e.due;
      q_a.push_back(e);
    end
    bcd_a   = v;
    start_a = 1'b1;
    @(negedge i_Clock);
    start_a = 1'b0;
    bcd_a   = ~v;
  endtask

  task automatic go_b(input logic [7:0] v);
    exp_t e;
    if (cyc >= last_due_b) begin
      model(int'(v), 2, 4, e.bin, e.err, e.ovf);
      e.st = cyc + 1;
      e.due = cyc + 1 + LAT_B;
      last_due_b = e.due;
      q_b.push_back(e);
    end
    bcd_b   = v;
    start_b = 1'b1;
    @(negedge i_Clock);
    start_b = 1'b0;
    bcd_b   = ~v;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (((cyc < last_due_a) || (cyc < last_due_b)) && (guard < 500)) begin
      @(negedge i_Clock);
      guard = guard + 1;
    end
    check("wait_bound", guard < 500, 1);
  endtask

  typedef struct {
    int bcd;
    int nd;
    int w;
    int bin;
    bit err;
    bit ovf;
  } pin_t;

  pin_t pins[$] = '{
    '{32'h999, 3, 10, 999, 1'b0, 1'b0},
    '{32'h102, 3, 10, 102, 1'b0, 1'b0},
    '{32'h512, 3, 10, 512, 1'b0, 1'b0},
    '{32'h1A3, 3, 10,   0, 1'b1, 1'b0},
    '{32'h17,  2,  4,   1, 1'b0, 1'b1},
    '{32'h15,  2,  4,  15, 1'b0, 1'b0}
  };

  logic [11:0] sweep [5] = '{12'h000, 12'h010, 12'h255, 12'h512, 12'h102};

  initial begin
    int b;
    bit er, ov;

    foreach (pins[i]) begin
      model(pins[i].bcd, pins[i].nd, pins[i].w, b, er, ov);
      check("pin_bin", b, pins[i].bin);
      check("pin_err", er, pins[i].err);
      check("pin_ovf", ov, pins[i].ovf);
    end

    #1 i_Reset = 1'b1;
    #1;
    check("rst_bin_a", bin_a, 0);
    check("rst_dv_a", dv_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_bin_b", bin_b, 0);
    repeat (2) @(negedge i_Clock);
    i_Reset = 1'b0;
    @(negedge i_Clock);

    go_a(12'h999);
    wait_idle();
    foreach (sweep[i]) begin
      go_a(sweep[i]);
      wait_idle();
    end

    go_a(12'h1A3);
    wait_idle();
    go_a(12'h007);
    wait_idle();

    go_b(8'h17);
    wait_idle();
    go_b(8'h15);
    wait_idle();

    // Busy start is dropped; the one issued in the DV cycle is taken
    go_a(12'h999);
    repeat (19) @(negedge i_Clock);
    go_a(12'h321);
    wait_idle();
    go_a(12'h321);
    wait_idle();
    @(negedge i_Clock);
    check("hold_bin_a", bin_a, 321);

    go_a(12'h999);
    repeat (29) @(negedge i_Clock);
    #2 i_Reset = 1'b1;
    #1;
    check("mid_rst_bin_a", bin_a, 0);
    check("mid_rst_dv_a", dv_a, 0);
    check("mid_rst_busy_a", busy_a, 0);
    check("mid_rst_err_a", err_a, 0);
    check("mid_rst_ovf_a", ovf_a, 0);
    check("mid_rst_bin_b", bin_b, 0);
    q_a.delete();
    q_b.delete();
    last_due_a = cyc;
    last_due_b = cyc;
    @(negedge i_Clock);
    i_Reset = 1'b0;
    repeat (80) @(negedge i_Clock);

    go_a(12'h042);
    wait_idle();
    repeat (3) @(negedge i_Clock);

    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
